// File: rtl/fact_pkg.sv
// Shared types and constants for the memory-mapped factorial peripheral.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        RSEL_N,
        RSEL_GO,
        RSEL_STATUS,
        RSEL_RESULT,
        RSEL_NONE
    } rsel_e;

    localparam int unsigned OFF_N      = 0;
    localparam int unsigned OFF_GO     = 1;
    localparam int unsigned OFF_STATUS = 2;
    localparam int unsigned OFF_RESULT = 3;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_BUSY = 1;
    localparam int unsigned ST_ERR  = 2;
    localparam int unsigned ST_W    = 3;

endpackage

// File: rtl/fact_addr_dec.sv
// Word-offset decoder: one-hot write enables and a read-select for the register map.
module fact_addr_dec
    import fact_pkg::*;
#(
    parameter int unsigned ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] a,
    input  logic              we,
    output logic              we_n,
    output logic              we_go,
    output rsel_e             rsel_c
);

    always_comb begin
        we_n   = 1'b0;
        we_go  = 1'b0;
        rsel_c = RSEL_NONE;
        if (a == ADDR_W'(OFF_N)) begin
            we_n   = we;
            rsel_c = RSEL_N;
        end else if (a == ADDR_W'(OFF_GO)) begin
            we_go  = we;
            rsel_c = RSEL_GO;
        end else if (a == ADDR_W'(OFF_STATUS)) begin
            rsel_c = RSEL_STATUS;
        end else if (a == ADDR_W'(OFF_RESULT)) begin
            rsel_c = RSEL_RESULT;
        end
    end

endmodule

// File: rtl/fact_mmio.sv
// Memory-mapped factorial peripheral: N/GO/STATUS/RESULT registers around an
// iterative multiply engine with sticky done/err flags.
module fact_mmio
    import fact_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_W    = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A,
    input  logic              WE,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    state_e            state;
    logic [N_W-1:0]    n_reg;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] prod;
    logic              we_n;
    logic              we_go;
    rsel_e             rsel_c;
    logic              go_req_c;
    logic [PROD_W-1:0] full_c;
    logic              ovf_c;
    logic [ST_W-1:0]   status_c;
    logic              unused_wd;

    fact_addr_dec #(
        .ADDR_W(ADDR_W)
    ) u_dec (
        .a     (A),
        .we    (WE),
        .we_n  (we_n),
        .we_go (we_go),
        .rsel_c(rsel_c)
    );

    assign go_req_c  = we_go & WD[0];
    assign full_c    = PROD_W'(prod) * PROD_W'(cnt);
    assign ovf_c     = |full_c[PROD_W-1:DATA_W];
    assign busy      = (state == BUSY);
    assign unused_wd = ^WD[DATA_W-1:N_W];

    // N register: writable at any time, never disturbs a running count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= '0;
        end else if (we_n) begin
            n_reg <= WD[N_W-1:0];
        end
    end

    // Engine: GO only accepted outside BUSY; overflow saturates and ends the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go_req_c) begin
                        state <= BUSY;
                        cnt   <= n_reg;
                        prod  <= DATA_W'(1);
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt > N_W'(1)) begin
                        cnt <= cnt - N_W'(1);
                        if (ovf_c) begin
                            prod  <= '1;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            prod <= full_c[DATA_W-1:0];
                        end
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_c          = '0;
        status_c[ST_DONE] = done;
        status_c[ST_BUSY] = busy;
        status_c[ST_ERR]  = err;
    end

    always_comb begin
        RD = '0;
        case (rsel_c)
            RSEL_N:      RD = DATA_W'(n_reg);
            RSEL_GO:     RD = DATA_W'(busy);
            RSEL_STATUS: RD = DATA_W'(status_c);
            RSEL_RESULT: RD = prod;
            default:     RD = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_mmio.sv
// Directed self-checking bench for fact_mmio with hand-computed factorials.
module tb_fact_mmio;

    logic        clk;
    logic        rst_n;
    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    fact_mmio #(
        .DATA_W(32),
        .N_W   (4),
        .ADDR_W(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .WE   (WE),
        .WD   (WD),
        .RD   (RD),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        A = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        A  = a;
        WD = d;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
        WD = '0;
    endtask

    task automatic flags(input string tag, input logic b, input logic d, input logic e);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".err"},  32'(err),  32'(e));
    endtask

    task automatic wait_done(input int bound, input string tag);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        assert (done === 1'b1)
        else begin
            n_bad++;
            $error("FAIL %s: done not seen within %0d cycles (observed %b expected 1)", tag, bound, done);
        end
    endtask

    // Checks busy/done cycle by cycle after a GO edge for the given latency
    task automatic run_latency(input int lat, input string tag);
        for (int i = 0; i < lat; i++) begin
            check($sformatf("%s.busy@%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s.done@%0d", tag, i), 32'(done), 32'd0);
            @(negedge clk);
        end
        flags({tag, ".end"}, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (observed timeout expected finish)");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        A     = '0;
        WE    = 1'b0;
        WD    = '0;
        repeat (2) @(negedge clk);
        flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of the register map
        rd(2'd0, 32'd0, "rst.N");
        rd(2'd1, 32'd0, "rst.GO");
        rd(2'd2, 32'd0, "rst.STATUS");
        rd(2'd3, 32'd0, "rst.RESULT");
        flags("rst.after", 1'b0, 1'b0, 1'b0);

        // GO with WD[0]=0 must not start
        wr(2'd1, 32'd2);
        flags("go0", 1'b0, 1'b0, 1'b0);

        // 5! with exact latency
        wr(2'd0, 32'd5);
        rd(2'd0, 32'd5, "n5.readback");
        wr(2'd1, 32'd1);
        rd(2'd1, 32'd1, "n5.GOread");
        run_latency(5, "n5");
        rd(2'd3, 32'd120, "n5.RESULT");
        rd(2'd2, 32'd1, "n5.STATUS");
        rd(2'd1, 32'd0, "n5.GOidle");

        // 0! and 1! both finish after one cycle
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd1);
        run_latency(1, "n0");
        rd(2'd3, 32'd1, "n0.RESULT");
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd1);
        run_latency(1, "n1");
        rd(2'd3, 32'd1, "n1.RESULT");

        // 13! overflows 32 bits
        wr(2'd0, 32'd13);
        wr(2'd1, 32'd1);
        wait_done(40, "n13.wait");
        flags("n13", 1'b0, 1'b1, 1'b1);
        rd(2'd3, 32'hFFFF_FFFF, "n13.RESULT");
        rd(2'd2, 32'd5, "n13.STATUS");

        // 12! fits; err clears on acceptance
        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        flags("n12.start", 1'b1, 1'b0, 1'b0);
        wait_done(40, "n12.wait");
        flags("n12", 1'b0, 1'b1, 1'b0);
        rd(2'd3, 32'd479001600, "n12.RESULT");

        // N and GO writes during a run do not disturb it
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        check("n6.stillbusy", 32'(busy), 32'd1);
        wait_done(40, "n6.wait");
        rd(2'd3, 32'd720, "n6.RESULT");
        rd(2'd0, 32'd3, "n6.Nreg");
        wr(2'd3, 32'hDEAD_BEEF);
        rd(2'd3, 32'd720, "n6.RESULTro");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'd1, "n6.STATUSro");

        // Asynchronous reset in the middle of a run
        wr(2'd0, 32'd7);
        wr(2'd1, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        flags("arst", 1'b0, 1'b0, 1'b0);
        rd(2'd0, 32'd0, "arst.N");
        rd(2'd1, 32'd0, "arst.GO");
        rd(2'd2, 32'd0, "arst.STATUS");
        rd(2'd3, 32'd0, "arst.RESULT");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh run after reset
        wr(2'd0, 32'd4);
        wr(2'd1, 32'd1);
        run_latency(4, "n4");
        rd(2'd3, 32'd24, "n4.RESULT");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
